// File: rtl/synth_alloc_pkg.sv
// Shared definitions for the multitimbral note front end.
// Contents: MIDI status-nibble constants, the sustain controller number,
// the byte-parser state type, the parsed-message record and small helpers
// for decoding message length and recognising the sustain controller.
package synth_alloc_pkg;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] POLY_AFT   = 4'hA;
  localparam logic [3:0] CTRL       = 4'hB;
  localparam logic [3:0] PRG        = 4'hC;
  localparam logic [3:0] AFT        = 4'hD;
  localparam logic [3:0] PITCH      = 4'hE;
  localparam logic [7:0] CC_SUSTAIN = 8'd64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    D1   = 2'd1,
    D2   = 2'd2
  } parse_state_t;

  // part is kept at full channel width; the top truncates to P_WIDTH
  typedef struct packed {
    logic [3:0] status;
    logic [3:0] part;
    logic [7:0] d1;
    logic [7:0] d2;
  } midi_msg_t;

  // Number of data bytes carried by a channel message (0 = not a channel status)
  function automatic logic [1:0] msg_len(input logic [3:0] st);
    case (st)
      NOTE_OFF, NOTE_ON, POLY_AFT, CTRL, PITCH: msg_len = 2'd2;
      PRG, AFT:                                 msg_len = 2'd1;
      default:                                  msg_len = 2'd0;
    endcase
  endfunction

  function automatic logic is_sustain_cc(input midi_msg_t m);
    is_sustain_cc = (m.status == CTRL) && (m.d1 == CC_SUSTAIN);
  endfunction

endpackage

// File: rtl/voice_age_picker.sv
// Per-voice age counters and allocation candidate search.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   keys_on, voice_free gate vector and engine-idle vector
//   touch, touch_idx    a note-on landed on touch_idx: clear its age, age all others
//   free_found/free_idx lowest voice that is gated off and idle
//   rel_found/rel_idx   oldest gated-off voice (ties -> lowest index)
//   old_idx             oldest voice overall (ties -> lowest index)
//   steal               no gated-off voice exists, a held voice must be taken
module voice_age_picker #(
  parameter int VOICES  = 16,
  parameter int V_WIDTH = 4,
  parameter int AGE_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VOICES-1:0]  keys_on,
  input  logic [VOICES-1:0]  voice_free,
  input  logic               touch,
  input  logic [V_WIDTH-1:0] touch_idx,
  output logic               free_found,
  output logic [V_WIDTH-1:0] free_idx,
  output logic               rel_found,
  output logic [V_WIDTH-1:0] rel_idx,
  output logic [V_WIDTH-1:0] old_idx,
  output logic               steal
);

  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  logic [AGE_W-1:0] age [VOICES];
  logic [AGE_W-1:0] rel_age;
  logic [AGE_W-1:0] old_age;

  // Age counters: touched voice restarts at zero, the rest count up and saturate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) age[i] <= '0;
    end else if (touch) begin
      for (int i = 0; i < VOICES; i++) begin
        if (V_WIDTH'(i) == touch_idx) age[i] <= '0;
        else if (age[i] != AGE_MAX)   age[i] <= age[i] + 1'b1;
      end
    end
  end

  // Candidate search; strict '>' keeps the lowest index on age ties
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    rel_found  = 1'b0;
    rel_idx    = '0;
    rel_age    = '0;
    old_idx    = '0;
    old_age    = age[0];
    for (int i = 0; i < VOICES; i++) begin
      if (!keys_on[i] && voice_free[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = V_WIDTH'(i);
      end else begin
        free_found = free_found;
      end
      if (!keys_on[i] && (!rel_found || (age[i] > rel_age))) begin
        rel_found = 1'b1;
        rel_idx   = V_WIDTH'(i);
        rel_age   = age[i];
      end else begin
        rel_found = rel_found;
      end
      if (age[i] > old_age) begin
        old_idx = V_WIDTH'(i);
        old_age = age[i];
      end else begin
        old_idx = old_idx;
      end
    end
    steal = !rel_found;
  end

endmodule

// File: rtl/multitimbral_voice_alloc.sv
// Multitimbral note front end: MIDI running-status parser, part filter and
// age-based voice allocator driving note events and the voice gate vector.
// Optional build macro: SUSTAIN_PEDAL_EN (per-part CC64 sustain with flush).
// Ports:
//   reg_clk, reset_reg_N   clock, async active-low reset
//   byteready/midi_in_data one-cycle byte strobe and raw MIDI byte
//   base_ch                first served channel; part p = channel base_ch+p
//   voice_free             per-voice envelope idle from the engine
//   note_on/note_off       one-cycle event strobes
//   ev_voice/ev_part/ev_key/ev_vel  event payload, held between strobes
//   voice_steal            pulses with note_on when a held voice was taken
//   keys_on/active_keys    voice gate vector and its population count
module multitimbral_voice_alloc
  import synth_alloc_pkg::*;
#(
  parameter int VOICES   = 16,
  parameter int V_WIDTH  = 4,
  parameter int CHANNELS = 4,
  parameter int P_WIDTH  = 2,
  parameter int AGE_W    = 8
) (
  input  logic               reg_clk,
  input  logic               reset_reg_N,
  input  logic               byteready,
  input  logic [7:0]         midi_in_data,
  input  logic [3:0]         base_ch,
  input  logic [VOICES-1:0]  voice_free,
  output logic               note_on,
  output logic               note_off,
  output logic [V_WIDTH-1:0] ev_voice,
  output logic [P_WIDTH-1:0] ev_part,
  output logic [7:0]         ev_key,
  output logic [7:0]         ev_vel,
  output logic               voice_steal,
  output logic [VOICES-1:0]  keys_on,
  output logic [V_WIDTH:0]   active_keys
);

  localparam logic [4:0] CH_LIM = 5'(CHANNELS);

  function automatic logic [V_WIDTH:0] popcount(input logic [VOICES-1:0] v);
    popcount = '0;
    for (int i = 0; i < VOICES; i++) popcount = popcount + {{V_WIDTH{1'b0}}, v[i]};
  endfunction

  // ---------------- parser ----------------
  parse_state_t state, state_nx;
  logic [7:0]   run_status;
  logic [7:0]   d1_byte;
  logic         complete, latch_status, latch_d1, sys_common;
  logic [3:0]   msg_part;
  midi_msg_t    msg;
  logic         msg_valid;

  // Parser state register
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) state <= IDLE;
    else              state <= state_nx;
  end

  // Parser next state; realtime bytes leave everything untouched
  always_comb begin
    state_nx     = state;
    complete     = 1'b0;
    latch_status = 1'b0;
    latch_d1     = 1'b0;
    sys_common   = 1'b0;
    if (byteready) begin
      if (midi_in_data[7]) begin
        if (midi_in_data < 8'hF0) begin
          latch_status = 1'b1;
          state_nx     = D1;
        end else if (midi_in_data < 8'hF8) begin
          sys_common = 1'b1;
          state_nx   = IDLE;
        end else begin
          state_nx = state;
        end
      end else begin
        case (state)
          D1: begin
            latch_d1 = 1'b1;
            if (msg_len(run_status[7:4]) == 2'd1) begin
              complete = 1'b1;
              state_nx = D1;
            end else begin
              state_nx = D2;
            end
          end
          D2: begin
            complete = 1'b1;
            state_nx = D1;
          end
          default: state_nx = state;
        endcase
      end
    end else begin
      state_nx = state;
    end
  end

  assign msg_part = run_status[3:0] - base_ch;

  // Running status / first data byte latches and the message register
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      run_status <= 8'h00;
      d1_byte    <= 8'h00;
      msg        <= '0;
      msg_valid  <= 1'b0;
    end else begin
      if (latch_status)    run_status <= midi_in_data;
      else if (sys_common) run_status <= 8'h00;
      if (latch_d1) d1_byte <= midi_in_data;
      msg_valid <= complete && ({1'b0, msg_part} < CH_LIM);
      if (complete) begin
        msg.status <= run_status[7:4];
        msg.part   <= msg_part;
        // one-byte messages complete in D1 with the current byte as d1
        msg.d1     <= (state == D2) ? d1_byte : midi_in_data;
        msg.d2     <= (state == D2) ? midi_in_data : 8'h00;
      end
    end
  end

  // ---------------- allocator ----------------
  midi_msg_t          proc_msg;
  logic               proc_valid;
  logic [P_WIDTH-1:0] proc_part;
  logic [7:0]         key_tab  [VOICES];
  logic [P_WIDTH-1:0] part_tab [VOICES];
  logic [VOICES-1:0]  off_block;
  logic               on_hit, off_hit;
  logic [V_WIDTH-1:0] on_idx, off_idx;
  logic               is_on, is_off;
  logic               free_found, rel_found, steal;
  logic [V_WIDTH-1:0] free_idx, rel_idx, old_idx;
  logic [VOICES-1:0]  keys_on_nx;
  logic               ev_on_nx, ev_off_nx, steal_nx, touch;
  logic [V_WIDTH-1:0] ev_idx;
  logic [7:0]         ev_key_nx, ev_vel_nx;
  logic [P_WIDTH-1:0] ev_part_nx;
  logic               unused_part_bits;

`ifdef SUSTAIN_PEDAL_EN
  logic [CHANNELS-1:0] sustain, sustain_nx;
  logic [VOICES-1:0]   sustained, sustained_nx;
  logic                flushing, flushing_nx;
  logic [P_WIDTH-1:0]  flush_part, flush_part_nx;
  logic                flush_hit, busy;
  logic [V_WIDTH-1:0]  flush_idx;
  logic                hold_valid;
  midi_msg_t           hold_msg;

  assign busy       = flushing && flush_hit;
  assign proc_valid = !busy && (hold_valid || msg_valid);
  assign proc_msg   = hold_valid ? hold_msg : msg;
  // released-but-sustained voices must not absorb a second note-off
  assign off_block  = sustained;

  // Lowest sustained voice of the part being flushed
  always_comb begin
    flush_hit = 1'b0;
    flush_idx = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (sustained[i] && (part_tab[i] == flush_part) && !flush_hit) begin
        flush_hit = 1'b1;
        flush_idx = V_WIDTH'(i);
      end else begin
        flush_hit = flush_hit;
      end
    end
  end

  // Sustain state and the one-deep holding register for messages that arrive mid-flush
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      sustain    <= '0;
      sustained  <= '0;
      flushing   <= 1'b0;
      flush_part <= '0;
      hold_valid <= 1'b0;
      hold_msg   <= '0;
    end else begin
      sustain    <= sustain_nx;
      sustained  <= sustained_nx;
      flushing   <= flushing_nx;
      flush_part <= flush_part_nx;
      if (msg_valid && (busy || hold_valid)) begin
        hold_msg   <= msg;
        hold_valid <= 1'b1;
      end else if (hold_valid && !busy) begin
        hold_valid <= 1'b0;
      end
    end
  end
`else
  assign proc_valid = msg_valid;
  assign proc_msg   = msg;
  assign off_block  = '0;
`endif

  assign proc_part        = proc_msg.part[P_WIDTH-1:0];
  assign unused_part_bits = ^proc_msg.part;
  assign is_on  = proc_valid && (proc_msg.status == NOTE_ON) && (proc_msg.d2 != 8'h00);
  assign is_off = proc_valid && ((proc_msg.status == NOTE_OFF) ||
                  ((proc_msg.status == NOTE_ON) && (proc_msg.d2 == 8'h00)));

  // Lowest held voice carrying this key on this part
  always_comb begin
    on_hit  = 1'b0;
    on_idx  = '0;
    off_hit = 1'b0;
    off_idx = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (keys_on[i] && (key_tab[i] == proc_msg.d1) && (part_tab[i] == proc_part)) begin
        if (!on_hit) begin
          on_hit = 1'b1;
          on_idx = V_WIDTH'(i);
        end else begin
          on_hit = on_hit;
        end
        if (!off_hit && !off_block[i]) begin
          off_hit = 1'b1;
          off_idx = V_WIDTH'(i);
        end else begin
          off_hit = off_hit;
        end
      end else begin
        on_hit = on_hit;
      end
    end
  end

  voice_age_picker #(
    .VOICES (VOICES),
    .V_WIDTH(V_WIDTH),
    .AGE_W  (AGE_W)
  ) u_picker (
    .clk       (reg_clk),
    .rst_n     (reset_reg_N),
    .keys_on   (keys_on),
    .voice_free(voice_free),
    .touch     (touch),
    .touch_idx (ev_idx),
    .free_found(free_found),
    .free_idx  (free_idx),
    .rel_found (rel_found),
    .rel_idx   (rel_idx),
    .old_idx   (old_idx),
    .steal     (steal)
  );

  // Event decision: flush step (sustain build) has priority over message processing
  always_comb begin
    keys_on_nx = keys_on;
    ev_on_nx   = 1'b0;
    ev_off_nx  = 1'b0;
    steal_nx   = 1'b0;
    touch      = 1'b0;
    ev_idx     = '0;
    ev_key_nx  = proc_msg.d1;
    ev_vel_nx  = proc_msg.d2;
    ev_part_nx = proc_part;
`ifdef SUSTAIN_PEDAL_EN
    sustain_nx    = sustain;
    sustained_nx  = sustained;
    flushing_nx   = flushing;
    flush_part_nx = flush_part;
    if (busy) begin
      ev_off_nx               = 1'b1;
      ev_idx                  = flush_idx;
      ev_key_nx               = key_tab[flush_idx];
      ev_part_nx              = flush_part;
      ev_vel_nx               = 8'h00;
      keys_on_nx[flush_idx]   = 1'b0;
      sustained_nx[flush_idx] = 1'b0;
    end else begin
      flushing_nx = 1'b0;
    end
`endif
    if (is_on) begin
      ev_on_nx = 1'b1;
      touch    = 1'b1;
      if (on_hit)          ev_idx = on_idx;
      else if (free_found) ev_idx = free_idx;
      else if (rel_found)  ev_idx = rel_idx;
      else begin
        ev_idx   = old_idx;
        steal_nx = steal;
      end
      keys_on_nx[ev_idx] = 1'b1;
`ifdef SUSTAIN_PEDAL_EN
      sustained_nx[ev_idx] = 1'b0;
`endif
    end else if (is_off && off_hit) begin
`ifdef SUSTAIN_PEDAL_EN
      if (sustain[proc_part]) begin
        sustained_nx[off_idx] = 1'b1;
      end else begin
        ev_off_nx           = 1'b1;
        ev_idx              = off_idx;
        keys_on_nx[off_idx] = 1'b0;
      end
`else
      ev_off_nx           = 1'b1;
      ev_idx              = off_idx;
      keys_on_nx[off_idx] = 1'b0;
`endif
    end
`ifdef SUSTAIN_PEDAL_EN
    else if (proc_valid && is_sustain_cc(proc_msg)) begin
      if (proc_msg.d2 >= 8'd64) begin
        sustain_nx[proc_part] = 1'b1;
      end else begin
        sustain_nx[proc_part] = 1'b0;
        if (sustain[proc_part]) begin
          flushing_nx   = 1'b1;
          flush_part_nx = proc_part;
        end else begin
          flushing_nx = flushing_nx;
        end
      end
    end
`endif
    else begin
      keys_on_nx = keys_on_nx;
    end
  end

  // Registered outputs and per-voice key/part tables
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      note_on     <= 1'b0;
      note_off    <= 1'b0;
      voice_steal <= 1'b0;
      ev_voice    <= '0;
      ev_part     <= '0;
      ev_key      <= 8'h00;
      ev_vel      <= 8'h00;
      keys_on     <= '0;
      active_keys <= '0;
      for (int i = 0; i < VOICES; i++) begin
        key_tab[i]  <= 8'h00;
        part_tab[i] <= '0;
      end
    end else begin
      note_on     <= ev_on_nx;
      note_off    <= ev_off_nx;
      voice_steal <= steal_nx;
      keys_on     <= keys_on_nx;
      active_keys <= popcount(keys_on_nx);
      if (ev_on_nx || ev_off_nx) begin
        ev_voice <= ev_idx;
        ev_part  <= ev_part_nx;
        ev_key   <= ev_key_nx;
        ev_vel   <= ev_vel_nx;
      end
      if (ev_on_nx) begin
        key_tab[ev_idx]  <= proc_msg.d1;
        part_tab[ev_idx] <= proc_part;
      end
    end
  end

endmodule

// File: tb/tb_multitimbral_voice_alloc.sv
// Directed-vector bench for multitimbral_voice_alloc (default parameters).
// Covers the SUSTAIN_PEDAL_EN build when the macro is defined, otherwise
// checks that CC64 has no effect.
module tb_multitimbral_voice_alloc;

  logic        reg_clk = 1'b0;
  logic        reset_reg_N;
  logic        byteready;
  logic [7:0]  midi_in_data;
  logic [3:0]  base_ch;
  logic [15:0] voice_free;
  logic        note_on, note_off, voice_steal;
  logic [3:0]  ev_voice;
  logic [1:0]  ev_part;
  logic [7:0]  ev_key, ev_vel;
  logic [15:0] keys_on;
  logic [4:0]  active_keys;

  int errors = 0;
  int checks = 0;

  multitimbral_voice_alloc dut (
    .reg_clk     (reg_clk),
    .reset_reg_N (reset_reg_N),
    .byteready   (byteready),
    .midi_in_data(midi_in_data),
    .base_ch     (base_ch),
    .voice_free  (voice_free),
    .note_on     (note_on),
    .note_off    (note_off),
    .ev_voice    (ev_voice),
    .ev_part     (ev_part),
    .ev_key      (ev_key),
    .ev_vel      (ev_vel),
    .voice_steal (voice_steal),
    .keys_on     (keys_on),
    .active_keys (active_keys)
  );

  always #5 reg_clk = ~reg_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge reg_clk);
    byteready    = 1'b1;
    midi_in_data = b;
    @(negedge reg_clk);
    byteready    = 1'b0;
  endtask

  task automatic msg3(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
    send(s); send(a); send(b);
  endtask

  task automatic do_reset();
    @(negedge reg_clk);
    reset_reg_N = 1'b0;
    byteready   = 1'b0;
    @(negedge reg_clk);
    reset_reg_N = 1'b1;
    @(negedge reg_clk);
  endtask

  // final byte sampled at edge E0; outputs register at the following edge
  task automatic expect_on(input string tag, input int v, input int part,
                           input int key, input int vel, input int stl);
    @(posedge reg_clk); #1;
    check({tag, " note_on"}, note_on, 1);
    check({tag, " note_off"}, note_off, 0);
    check({tag, " voice"}, ev_voice, v);
    check({tag, " part"}, ev_part, part);
    check({tag, " key"}, ev_key, key);
    check({tag, " vel"}, ev_vel, vel);
    check({tag, " steal"}, voice_steal, stl);
    @(posedge reg_clk); #1;
    check({tag, " strobe"}, note_on, 0);
  endtask

  task automatic expect_off(input string tag, input int v, input int key, input int vel);
    @(posedge reg_clk); #1;
    check({tag, " note_off"}, note_off, 1);
    check({tag, " note_on"}, note_on, 0);
    check({tag, " voice"}, ev_voice, v);
    check({tag, " key"}, ev_key, key);
    check({tag, " vel"}, ev_vel, vel);
    @(posedge reg_clk); #1;
    check({tag, " strobe"}, note_off, 0);
  endtask

  task automatic expect_none(input string tag);
    @(posedge reg_clk); #1;
    check({tag, " no event"}, {note_on, note_off}, 0);
    @(posedge reg_clk); #1;
    check({tag, " no late event"}, {note_on, note_off}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_reg_N  = 1'b0;
    byteready    = 1'b0;
    midi_in_data = 8'h00;
    base_ch      = 4'd0;
    voice_free   = 16'hFFFF;
    #12;
    check("reset outputs", {note_on, note_off, voice_steal, ev_voice, ev_part, ev_key, ev_vel}, 0);
    check("reset keys", {keys_on, active_keys}, 0);
    do_reset();

    // basic note-on
    msg3(8'h90, 8'h3C, 8'h64);
    expect_on("basic", 0, 0, 8'h3C, 8'h64, 0);
    check("basic keys_on", keys_on, 16'h0001);
    check("basic active", active_keys, 1);

    // running status on part 1, then note-off
    do_reset();
    msg3(8'h91, 8'h40, 8'h50);
    expect_on("rs first", 0, 1, 8'h40, 8'h50, 0);
    send(8'h42); send(8'h50);
    expect_on("rs second", 1, 1, 8'h42, 8'h50, 0);
    msg3(8'h81, 8'h40, 8'h00);
    expect_off("rs off", 0, 8'h40, 8'h00);
    check("rs keys_on", keys_on, 16'h0002);
    check("rs active", active_keys, 1);
    msg3(8'h81, 8'h55, 8'h10);
    expect_none("off no match");
    check("off no match keys", keys_on, 16'h0002);
    msg3(8'h91, 8'h42, 8'h33);
    expect_on("retrigger", 1, 1, 8'h42, 8'h33, 0);
    check("retrigger keys", keys_on, 16'h0002);
    msg3(8'h91, 8'h42, 8'h00);
    expect_off("vel0 off", 1, 8'h42, 8'h00);
    check("vel0 off keys", keys_on, 16'h0000);

    // candidate priority: idle voice first, then oldest released voice
    do_reset();
    voice_free = 16'h0004;
    msg3(8'h90, 8'h3C, 8'h64);
    expect_on("free pick", 2, 0, 8'h3C, 8'h64, 0);
    voice_free = 16'h0000;
    msg3(8'h90, 8'h3D, 8'h64);
    expect_on("released pick", 0, 0, 8'h3D, 8'h64, 0);

    // fill all voices then steal the oldest
    do_reset();
    for (int k = 0; k < 16; k++) begin
      msg3(8'h90, 8'(48 + k), 8'h7F);
      expect_on("fill", k, 0, 48 + k, 8'h7F, 0);
    end
    check("fill keys", keys_on, 16'hFFFF);
    check("fill active", active_keys, 16);
    msg3(8'h90, 8'h50, 8'h7F);
    expect_on("steal oldest", 0, 0, 8'h50, 8'h7F, 1);
    msg3(8'h90, 8'h51, 8'h7F);
    expect_on("steal next", 1, 0, 8'h51, 8'h7F, 1);
    check("steal active", active_keys, 16);

    // channel filter, realtime interleave, system common
    do_reset();
    voice_free = 16'hFFFF;
    base_ch = 4'd14;
    msg3(8'h91, 8'h3C, 8'h40);
    expect_on("wrap part", 0, 3, 8'h3C, 8'h40, 0);
    base_ch = 4'd0;
    msg3(8'h95, 8'h3C, 8'h40);
    expect_none("out of range part");
    send(8'h90); send(8'hF8); send(8'h3C); send(8'h40);
    expect_on("realtime skip", 1, 0, 8'h3C, 8'h40, 0);
    check("realtime keys", keys_on, 16'h0003);
    send(8'hF0); send(8'h3C); send(8'h40);
    expect_none("sysex drop");
    check("sysex keys", keys_on, 16'h0003);

    // reset in the middle of a message
    send(8'h90); send(8'h3C);
    @(negedge reg_clk);
    reset_reg_N = 1'b0;
    #1;
    check("midreset outputs", {note_on, note_off, ev_voice, ev_key, ev_vel}, 0);
    check("midreset keys", {keys_on, active_keys}, 0);
    @(negedge reg_clk);
    reset_reg_N = 1'b1;
    send(8'h64);
    expect_none("lone data after reset");
    msg3(8'h90, 8'h3E, 8'h22);
    expect_on("after reset", 0, 0, 8'h3E, 8'h22, 0);

    // sustain pedal
    do_reset();
`ifdef SUSTAIN_PEDAL_EN
    msg3(8'hB0, 8'h40, 8'h7F);
    expect_none("pedal down");
    msg3(8'h90, 8'h3C, 8'h64);
    expect_on("sus on a", 0, 0, 8'h3C, 8'h64, 0);
    msg3(8'h90, 8'h3E, 8'h64);
    expect_on("sus on b", 1, 0, 8'h3E, 8'h64, 0);
    msg3(8'h80, 8'h3C, 8'h00);
    expect_none("sus off a");
    msg3(8'h80, 8'h3E, 8'h00);
    expect_none("sus off b");
    check("sus held keys", keys_on, 16'h0003);
    msg3(8'hB0, 8'h40, 8'h00);
    @(posedge reg_clk);
    @(posedge reg_clk); #1;
    check("flush first off", note_off, 1);
    check("flush first voice", ev_voice, 0);
    check("flush first key", ev_key, 8'h3C);
    check("flush first vel", ev_vel, 0);
    @(posedge reg_clk); #1;
    check("flush second off", note_off, 1);
    check("flush second voice", ev_voice, 1);
    check("flush second key", ev_key, 8'h3E);
    @(posedge reg_clk); #1;
    check("flush done", note_off, 0);
    check("flush keys", keys_on, 16'h0000);
`else
    msg3(8'hB0, 8'h40, 8'h7F);
    expect_none("cc64 ignored");
    msg3(8'h90, 8'h3C, 8'h64);
    expect_on("nosus on", 0, 0, 8'h3C, 8'h64, 0);
    msg3(8'h80, 8'h3C, 8'h11);
    expect_off("nosus off", 0, 8'h3C, 8'h11);
    check("nosus keys", keys_on, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
